// File: rtl/t03_dpu_mux_ctrl_if.sv
// ----------------------------------------------------------------------------
// t03_dpu_mux_ctrl_if
// Bundle of the request/ack handshakes, latch load strobes and the nibble
// stream between the DPU-to-MUX sequencer and its surroundings.
//
// Signals:
//   coord_req, reg_req        level requests from the two requesters
//   coord_ack, reg_ack        one-cycle frame-complete pulses
//   new_input_select          latch load strobe, coordinate source
//   register_input            latch load strobe, register source
//   nibble_sel[IDX_W-1:0]     index of the nibble offered downstream
//   nib_valid / nib_ready     downstream valid/ready beat
//   nib_last                  final nibble of the frame is offered
//   busy                      sequencer is not idle
//   grant_src                 0 = coord, 1 = reg (current or last grant)
//
// Modports: master = the sequencer, slave = requesters plus consumer.
// ----------------------------------------------------------------------------
interface t03_dpu_mux_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             coord_req;
  logic             reg_req;
  logic             coord_ack;
  logic             reg_ack;
  logic             new_input_select;
  logic             register_input;
  logic [IDX_W-1:0] nibble_sel;
  logic             nib_valid;
  logic             nib_ready;
  logic             nib_last;
  logic             busy;
  logic             grant_src;

  modport master (
    input  coord_req, reg_req, nib_ready,
    output coord_ack, reg_ack, new_input_select, register_input,
           nibble_sel, nib_valid, nib_last, busy, grant_src
  );

  modport slave (
    output coord_req, reg_req, nib_ready,
    input  coord_ack, reg_ack, new_input_select, register_input,
           nibble_sel, nib_valid, nib_last, busy, grant_src
  );
endinterface

// File: rtl/t03_dpu_mux_ctrl.sv
// ----------------------------------------------------------------------------
// t03_dpu_mux_ctrl
// Sequencer for the DPU-to-MUX nibble latch. Arbitrates between the
// coordinate-update requester and the register-readback requester, pulses
// the matching latch load strobe for one cycle, streams NUM_NIBBLES nibble
// indices downstream with valid/ready, then acks the granted requester.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset (abandons any frame, no ack)
//   bus   t03_dpu_mux_ctrl_if.master (requests/acks, strobes, nibble stream)
//
// Build option:
//   T03_DPU_RR_ARB_EN  defined   -> round-robin arbitration under contention
//                      undefined -> fixed priority, coord always wins
//
// All outputs decode registered state only (Moore); no input-to-output path.
// ----------------------------------------------------------------------------
module t03_dpu_mux_ctrl #(
  parameter int NUM_NIBBLES = 9,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  t03_dpu_mux_ctrl_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] sel_reg,   sel_next;
  logic             grant_reg, grant_next;
  logic             winner;

`ifdef T03_DPU_RR_ARB_EN
  // ptr_reg names the source favoured on the next contention (0 = coord).
  logic ptr_reg, ptr_next;

  always_comb begin
    if (bus.coord_req && bus.reg_req) begin
      winner = ptr_reg;
    end else begin
      winner = bus.reg_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  // Coord wins whenever it is asking; reg only wins when alone.
  assign winner = ~bus.coord_req;
`endif

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
`ifdef T03_DPU_RR_ARB_EN
    ptr_next   = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.coord_req || bus.reg_req) begin
          grant_next = winner;
          state_next = LOAD;
        end
      end
      LOAD: begin
        sel_next   = '0;
        state_next = SEND;
      end
      SEND: begin
        // nib_valid is always high here, so ready alone completes a beat.
        if (bus.nib_ready) begin
          if (sel_reg == LAST_IDX) begin
            state_next = ACK;
          end else begin
            sel_next = sel_reg + IDX_W'(1);
          end
        end
      end
      ACK: begin
        sel_next   = '0;
        state_next = IDLE;
`ifdef T03_DPU_RR_ARB_EN
        // The source just served loses the next contention.
        ptr_next   = ~grant_reg;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      grant_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
    end
  end

  assign bus.busy             = (state_reg != IDLE);
  assign bus.new_input_select = (state_reg == LOAD) && !grant_reg;
  assign bus.register_input   = (state_reg == LOAD) &&  grant_reg;
  assign bus.nib_valid        = (state_reg == SEND);
  assign bus.nib_last         = (state_reg == SEND) && (sel_reg == LAST_IDX);
  assign bus.nibble_sel       = sel_reg;
  assign bus.coord_ack        = (state_reg == ACK) && !grant_reg;
  assign bus.reg_ack          = (state_reg == ACK) &&  grant_reg;
  assign bus.grant_src        = grant_reg;

endmodule

// File: tb/tb_t03_dpu_mux_ctrl.sv
// ----------------------------------------------------------------------------
// tb_t03_dpu_mux_ctrl
// Self-checking bench for t03_dpu_mux_ctrl. A transaction-level reference
// (active flag, load-done flag, count of accepted nibbles, grant, preferred
// source) predicts every output each cycle. Directed scenarios are followed
// by a randomized phase with requesters obeying the hold-until-ack rule,
// random ready and occasional resets. Define T03_DPU_RR_ARB_EN for both
// the DUT and this bench to check the round-robin build.
// ----------------------------------------------------------------------------
module tb_t03_dpu_mux_ctrl;
  localparam int N     = 9;
  localparam int IDX_W = 4;
`ifdef T03_DPU_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  t03_dpu_mux_ctrl_if #(.IDX_W(IDX_W)) bus ();

  t03_dpu_mux_ctrl #(.NUM_NIBBLES(N), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state.
  bit m_active, m_loaded, m_grant, m_ptr;
  int m_acc;

  // Drive controls.
  bit drv_rst, drv_coord, drv_reg, auto_req, ready_tog, chk_en;
  int ready_mode;  // 0 = always ready, 1 = toggling, 2 = random

  // Observation counters.
  int cnt_busy, cnt_nis, cnt_ri, cnt_cack, cnt_rack, cnt_beats, n_txn;
  int glog[$];

  task automatic clear_counts();
    cnt_busy = 0; cnt_nis = 0; cnt_ri = 0; cnt_cack = 0; cnt_rack = 0; cnt_beats = 0;
    glog.delete();
  endtask

  task automatic tick();
    bit e_strobe, e_valid, e_ack, rdy;
    @(negedge clk);
    e_strobe = m_active && !m_loaded;
    e_valid  = m_active && m_loaded && (m_acc < N);
    e_ack    = m_active && m_loaded && (m_acc == N);
    if (chk_en) begin
      chk("busy",             32'(bus.busy),             32'(m_active));
      chk("new_input_select", 32'(bus.new_input_select), 32'(e_strobe && !m_grant));
      chk("register_input",   32'(bus.register_input),   32'(e_strobe && m_grant));
      chk("nib_valid",        32'(bus.nib_valid),        32'(e_valid));
      chk("nib_last",         32'(bus.nib_last),         32'(e_valid && (m_acc == N - 1)));
      chk("coord_ack",        32'(bus.coord_ack),        32'(e_ack && !m_grant));
      chk("reg_ack",          32'(bus.reg_ack),          32'(e_ack && m_grant));
      chk("grant_src",        32'(bus.grant_src),        32'(m_grant));
      if (e_valid) chk("nibble_sel", 32'(bus.nibble_sel), 32'(m_acc));
    end
    cnt_busy += int'(bus.busy);
    cnt_nis  += int'(bus.new_input_select);
    cnt_ri   += int'(bus.register_input);
    cnt_cack += int'(bus.coord_ack);
    cnt_rack += int'(bus.reg_ack);
    if (bus.new_input_select) glog.push_back(0);
    if (bus.register_input)   glog.push_back(1);
    if (e_ack && !drv_rst) begin
      n_txn++;
      $display("txn %0d: %s frame done at %0t", n_txn, m_grant ? "reg" : "coord", $time);
    end

    if (auto_req) begin
      if (drv_coord) begin
        if (e_ack && !m_grant) drv_coord = ($urandom_range(7) == 0);
        else if ($urandom_range(39) == 0) drv_coord = 1'b0;
      end else drv_coord = ($urandom_range(3) == 0);
      if (drv_reg) begin
        if (e_ack && m_grant) drv_reg = ($urandom_range(7) == 0);
        else if ($urandom_range(39) == 0) drv_reg = 1'b0;
      end else drv_reg = ($urandom_range(3) == 0);
      drv_rst = ($urandom_range(299) == 0);
    end
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       begin rdy = ready_tog; ready_tog = ~ready_tog; end
      default: rdy = ($urandom_range(3) != 0);
    endcase
    rst           = drv_rst;
    bus.coord_req = drv_coord;
    bus.reg_req   = drv_reg;
    bus.nib_ready = rdy;
    if (e_valid && rdy) cnt_beats++;

    // Reference update for the coming clock edge.
    if (drv_rst) begin
      m_active = 0; m_loaded = 0; m_acc = 0; m_grant = 0; m_ptr = 0;
    end else if (!m_active) begin
      if (drv_coord || drv_reg) begin
        m_active = 1; m_loaded = 0; m_acc = 0;
        if (drv_coord && drv_reg) m_grant = RR ? m_ptr : 1'b0;
        else                      m_grant = drv_reg;
      end
    end else if (!m_loaded) begin
      m_loaded = 1;
    end else if (m_acc < N) begin
      if (rdy) m_acc++;
    end else begin
      m_active = 0;
      m_ptr    = !m_grant;
    end
  endtask

  // Tick until either ack appears, then drop both requests (hold-until-ack).
  task automatic run_until_ack(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.coord_ack || bus.reg_ack) seen = 1;
    end
    if (!seen) chk({tag, "_ack_timeout"}, 32'(0), 32'(1));
    drv_coord = 0;
    drv_reg   = 0;
  endtask

  initial begin
    bit found;
    rst = 1; bus.coord_req = 0; bus.reg_req = 0; bus.nib_ready = 0;
    drv_rst = 1; drv_coord = 0; drv_reg = 0; auto_req = 0; ready_mode = 0;
    ready_tog = 1; chk_en = 0; n_txn = 0;
    m_active = 0; m_loaded = 0; m_acc = 0; m_grant = 0; m_ptr = 0;
    tick();
    chk_en = 1;
    tick();
    drv_rst = 0;
    tick();
    chk("rst_busy",       32'(bus.busy),       32'(0));
    chk("rst_nibble_sel", 32'(bus.nibble_sel), 32'(0));
    chk("rst_grant_src",  32'(bus.grant_src),  32'(0));

    // Coord only, ready held high.
    clear_counts();
    ready_mode = 0; drv_coord = 1;
    run_until_ack("coord_only", 40);
    repeat (3) tick();
    chk("coord_only_busy_cycles", 32'(cnt_busy), 32'(N + 2));
    chk("coord_only_nis_count",   32'(cnt_nis),  32'(1));
    chk("coord_only_ri_count",    32'(cnt_ri),   32'(0));
    chk("coord_only_ack_count",   32'(cnt_cack), 32'(1));

    // Reg only, ready toggling.
    clear_counts();
    ready_mode = 1; drv_reg = 1;
    run_until_ack("reg_toggle", 60);
    repeat (3) tick();
    chk("reg_toggle_ri_count",  32'(cnt_ri),    32'(1));
    chk("reg_toggle_nis_count", 32'(cnt_nis),   32'(0));
    chk("reg_toggle_ack_count", 32'(cnt_rack),  32'(1));
    chk("reg_toggle_beats",     32'(cnt_beats), 32'(N));

    // Reset held two cycles while nibble 5 is on offer.
    ready_mode = 0; drv_coord = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.nib_valid && bus.nibble_sel == IDX_W'(5)) found = 1;
    end
    if (!found) chk("midsend_reach_sel5", 32'(0), 32'(1));
    clear_counts();
    drv_rst = 1; drv_coord = 0;
    tick();
    tick();
    drv_rst = 0;
    tick();
    chk("midsend_rst_busy",       32'(bus.busy),       32'(0));
    chk("midsend_rst_nibble_sel", 32'(bus.nibble_sel), 32'(0));
    repeat (15) tick();
    chk("midsend_rst_no_ack", 32'(cnt_cack + cnt_rack), 32'(0));

    // Both requests held continuously.
    clear_counts();
    drv_coord = 1; drv_reg = 1;
    repeat (52) tick();
    drv_coord = 0; drv_reg = 0;
    repeat (15) tick();
    chk("contend_grant_count_ge4", 32'(glog.size() >= 4), 32'(1));
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk($sformatf("contend_grant%0d", i), 32'(glog[i]), RR ? 32'(i % 2) : 32'(0));

    // Coord dropped mid-SEND still completes and acks once.
    clear_counts();
    drv_coord = 1;
    repeat (3) tick();
    drv_coord = 0;
    repeat (20) tick();
    chk("drop_ack_count", 32'(cnt_cack), 32'(1));
    chk("drop_nis_count", 32'(cnt_nis),  32'(1));
    chk("drop_idle_busy", 32'(bus.busy), 32'(0));

    // Randomized traffic.
    auto_req = 1; ready_mode = 2;
    repeat (2000) tick();
    auto_req = 0; drv_rst = 0; drv_coord = 0; drv_reg = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
